// File: rtl/bp_cfg_boot_sequencer.sv
// Boot-time config sequencer: walks a loader ROM and issues credit-limited cfg writes, then unfreezes the cores.
// Optional watchdog is compiled in when BP_CFG_BOOT_WATCHDOG_EN is defined.
module bp_cfg_boot_sequencer #(
  parameter int unsigned num_core_p        = 1,
  parameter int unsigned cfg_core_width_p  = 8,
  parameter int unsigned cfg_addr_width_p  = 16,
  parameter int unsigned cfg_data_width_p  = 32,
  parameter int unsigned max_credits_p     = 4,
  parameter int unsigned rom_els_p         = 16,
  parameter int unsigned timeout_width_p   = 10,
  localparam int unsigned rom_addr_width_lp = (rom_els_p > 1) ? $clog2(rom_els_p) : 1,
  localparam int unsigned pkt_width_lp      = cfg_core_width_p + cfg_addr_width_p + cfg_data_width_p,
  localparam int unsigned entry_width_lp    = 1 + pkt_width_lp
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         start_i,
  output logic                         rom_v_o,
  output logic [rom_addr_width_lp-1:0] rom_addr_o,
  input  logic [entry_width_lp-1:0]    rom_data_i,
  output logic [pkt_width_lp-1:0]      cfg_pkt_o,
  output logic                         cfg_v_o,
  input  logic                         cfg_ready_i,
  input  logic                         cfg_ack_v_i,
  output logic [num_core_p-1:0]        freeze_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o
);

  localparam int unsigned payload_width_lp = cfg_addr_width_p + cfg_data_width_p;
  localparam int unsigned cred_width_lp    = $clog2(max_credits_p + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    SEND  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_e;

  if (num_core_p == 0 || num_core_p >= (2 ** cfg_core_width_p) || timeout_width_p == 0) begin : g_param_check
    $error("bp_cfg_boot_sequencer: illegal parameterization");
  end

  state_e                         state_q, state_d;
  logic [rom_addr_width_lp-1:0]   ptr_q, ptr_d;
  logic [cred_width_lp-1:0]       cred_q, cred_d;
  logic [cfg_core_width_p-1:0]    cnt_q, cnt_d;
  logic [entry_width_lp-1:0]      entry_q, entry_d;
  logic                           err_q, err_d;
  logic                           rom_v_q, rom_v_d;
  logic                           cfg_v_q, cfg_v_d;
  logic [pkt_width_lp-1:0]        pkt_q, pkt_d;
  logic [num_core_p-1:0]          freeze_q, freeze_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;

  logic                           xfer;
  logic                           entry_done;
  logic                           ent_last;
  logic                           ent_bcast;
  logic [cfg_core_width_p-1:0]    nxt_core;
  logic                           cred_full;

`ifdef BP_CFG_BOOT_WATCHDOG_EN
  logic [timeout_width_p-1:0]     wd_q, wd_d;
  logic                           trip_q, trip_d;
`endif

  assign xfer      = cfg_v_q & cfg_ready_i;
  assign ent_last  = entry_q[entry_width_lp-1];
  assign ent_bcast = (entry_q[entry_width_lp-2 -: cfg_core_width_p] == '1);
  assign cred_full = (cred_q == cred_width_lp'(max_credits_p));

  // Next-state, credit accounting and registered-output decode
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cred_d     = cred_q;
    cnt_d      = cnt_q;
    entry_d    = entry_q;
    err_d      = err_q;
    entry_done = 1'b0;
    nxt_core   = '0;
`ifdef BP_CFG_BOOT_WATCHDOG_EN
    wd_d       = wd_q;
    trip_d     = trip_q;
`endif

    if (xfer && !cfg_ack_v_i) begin
      cred_d = cred_q - cred_width_lp'(1);
    end else if (!xfer && cfg_ack_v_i) begin
      if (cred_full) err_d = 1'b1;
      else           cred_d = cred_q + cred_width_lp'(1);
    end

    case (state_q)
      IDLE:  if (start_i) state_d = FETCH;
      FETCH: state_d = LATCH;
      LATCH: begin
        entry_d = rom_data_i;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (ent_bcast) begin
            cnt_d      = cnt_q + cfg_core_width_p'(1);
            entry_done = (cnt_q == cfg_core_width_p'(num_core_p - 1));
          end else begin
            entry_done = 1'b1;
          end
          if (entry_done) begin
            if (ent_last || (ptr_q == rom_addr_width_lp'(rom_els_p - 1))) begin
              state_d = DRAIN;
            end else begin
              ptr_d   = ptr_q + rom_addr_width_lp'(1);
              state_d = FETCH;
            end
          end
        end
      end
      DRAIN: if (cred_full) state_d = DONE;
      DONE:  state_d = DONE;
      default: state_d = IDLE;
    endcase

`ifdef BP_CFG_BOOT_WATCHDOG_EN
    // Watchdog: any progress clears it; hitting all ones aborts to DONE with cores still frozen
    if (state_q == SEND || state_q == DRAIN) begin
      if (xfer || cfg_ack_v_i)  wd_d = '0;
      else if (wd_q != '1)      wd_d = wd_q + timeout_width_p'(1);
      if ((wd_q == '1) && (state_d != DONE)) begin
        err_d   = 1'b1;
        trip_d  = 1'b1;
        state_d = DONE;
      end
    end else begin
      wd_d = '0;
    end
`endif

    nxt_core  = (entry_d[entry_width_lp-2 -: cfg_core_width_p] == '1)
              ? cnt_d : entry_d[entry_width_lp-2 -: cfg_core_width_p];
    pkt_d     = {nxt_core, entry_d[payload_width_lp-1:0]};
    rom_v_d   = (state_d == FETCH);
    cfg_v_d   = (state_d == SEND) && (cred_d != '0);
    busy_d    = state_d inside {FETCH, LATCH, SEND, DRAIN};
`ifdef BP_CFG_BOOT_WATCHDOG_EN
    done_d    = (state_d == DONE) && !trip_d;
`else
    done_d    = (state_d == DONE);
`endif
    freeze_d  = {num_core_p{~done_d}};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cred_q   <= cred_width_lp'(max_credits_p);
      cnt_q    <= '0;
      entry_q  <= '0;
      err_q    <= 1'b0;
      rom_v_q  <= 1'b0;
      cfg_v_q  <= 1'b0;
      pkt_q    <= '0;
      freeze_q <= '1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cred_q   <= cred_d;
      cnt_q    <= cnt_d;
      entry_q  <= entry_d;
      err_q    <= err_d;
      rom_v_q  <= rom_v_d;
      cfg_v_q  <= cfg_v_d;
      pkt_q    <= pkt_d;
      freeze_q <= freeze_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef BP_CFG_BOOT_WATCHDOG_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wd_q   <= '0;
      trip_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      trip_q <= trip_d;
    end
  end
`endif

  assign rom_v_o    = rom_v_q;
  assign rom_addr_o = ptr_q;
  assign cfg_pkt_o  = pkt_q;
  assign cfg_v_o    = cfg_v_q;
  assign freeze_o   = freeze_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Self-checking bench for bp_cfg_boot_sequencer: directed and randomized ROM images against a packet-list model.
module tb_bp_cfg_boot_sequencer;

  localparam int unsigned CW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned MC = 4;
  localparam int unsigned RE = 16;
  localparam int unsigned PW = CW + AW + DW;
  localparam int unsigned EW = 1 + PW;
  localparam int unsigned MAXCYC = 3000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          ready = 1'b0;
  logic          ack = 1'b0;
  logic          rom_v;
  logic [3:0]    rom_addr;
  logic [EW-1:0] rom_data = '0;
  logic [PW-1:0] pkt;
  logic          cfg_v;
  logic [NC-1:0] freeze;
  logic          busy, done, err;

  logic [EW-1:0] rom [RE];
  logic [PW-1:0] obs_q[$];
  logic [PW-1:0] exp_q[$];
  int unsigned   outstanding = 0;
  int unsigned   stab_bad = 0;
  int unsigned   cred_bad = 0;
  int unsigned   total = 0;
  int unsigned   bad = 0;
  logic          prev_stall = 1'b0;
  logic [PW-1:0] prev_pkt = '0;

  bp_cfg_boot_sequencer #(
    .num_core_p(NC), .cfg_core_width_p(CW), .cfg_addr_width_p(AW), .cfg_data_width_p(DW),
    .max_credits_p(MC), .rom_els_p(RE), .timeout_width_p(10)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start),
    .rom_v_o(rom_v), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .cfg_pkt_o(pkt), .cfg_v_o(cfg_v), .cfg_ready_i(ready), .cfg_ack_v_i(ack),
    .freeze_o(freeze), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  // Synchronous loader ROM: data valid the cycle after the read enable
  always @(posedge clk) if (rom_v) rom_data <= rom[rom_addr];

  // Transfer capture, outstanding-write tracking, stall stability and credit-limit checks
  always @(negedge clk) begin
    if (!reset_n) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall && (cfg_v !== 1'b1 || pkt !== prev_pkt)) stab_bad++;
      if (cfg_v === 1'b1 && outstanding >= MC) cred_bad++;
      if (cfg_v === 1'b1 && ready) begin
        obs_q.push_back(pkt);
        outstanding++;
      end
      if (ack && outstanding > 0) outstanding--;
      prev_stall = (cfg_v === 1'b1) && !ready;
      prev_pkt   = pkt;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  function automatic logic [EW-1:0] mk(input logic l, input logic [CW-1:0] c,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {l, c, a, d};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic a);
    @(posedge clk); #1;
    ready = r; ack = a; start = 1'b0;
  endtask

  task automatic tick_auto(input logic r);
    @(posedge clk); #1;
    ready = r; ack = (outstanding > 0); start = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; ready = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    obs_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < RE; i++) rom[i] = '0;
  endtask

  // Model: ROM order until 'last' or end of ROM; broadcast expands to cores 0..NC-1
  task automatic build_exp();
    logic [EW-1:0] e;
    exp_q.delete();
    for (int i = 0; i < RE; i++) begin
      e = rom[i];
      if (e[EW-2 -: CW] == {CW{1'b1}}) begin
        for (int k = 0; k < NC; k++) exp_q.push_back({CW'(k), e[AW+DW-1:0]});
      end else begin
        exp_q.push_back(e[PW-1:0]);
      end
      if (e[EW-1]) break;
    end
  endtask

  task automatic run_until_done(input int unsigned rpct, input int unsigned apct, input string tag);
    int unsigned n = 0;
    while (done !== 1'b1 && n < MAXCYC) begin
      @(posedge clk); #1;
      ready = ($urandom_range(99, 0) < rpct);
      ack   = (outstanding > 0) && ($urandom_range(99, 0) < apct);
      start = ($urandom_range(19, 0) == 0);
      n++;
    end
    ready = 1'b0; ack = 1'b0; start = 1'b0;
    check({tag, " done"}, 64'(done), 64'd1);
  endtask

  task automatic cmp_queue(input string tag);
    check({tag, " count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s pkt%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    logic [CW-1:0] c;
    #1;
    clear_rom();
    do_reset();

    check("rst freeze", 64'(freeze), 64'hF);
    check("rst busy",   64'(busy),   64'd0);
    check("rst done",   64'(done),   64'd0);
    check("rst err",    64'(err),    64'd0);
    check("rst cfg_v",  64'(cfg_v),  64'd0);
    check("rst rom_v",  64'(rom_v),  64'd0);
    check("rst addr",   64'(rom_addr), 64'd0);
    check("rst pkt",    64'(pkt),    64'd0);

    // Spurious ack with full credits in IDLE
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("idle ack err",  64'(err),  64'd1);
    check("idle ack busy", 64'(busy), 64'd0);

    // Single unicast write
    do_reset();
    check("rst clears err", 64'(err), 64'd0);
    clear_rom();
    rom[0] = mk(1'b1, 8'h00, 16'h0010, 32'hDEADBEEF);
    build_exp();
    pulse_start();
    run_until_done(100, 100, "uni");
    cmp_queue("uni");
    check("uni literal", 64'((obs_q.size() > 0) ? obs_q[0] : '0), 64'h00_0010_DEADBEEF);
    check("uni freeze", 64'(freeze), 64'h0);
    check("uni busy",   64'(busy),   64'd0);
    check("uni err",    64'(err),    64'd0);
    pulse_start();
    repeat (10) tick(1'b1, 1'b0);
    check("done ignores start", 64'(obs_q.size()), 64'd1);
    check("done held", 64'(done), 64'd1);

    // Broadcast to four cores
    do_reset();
    clear_rom();
    rom[0] = mk(1'b1, 8'hFF, 16'h0004, 32'h1);
    build_exp();
    pulse_start();
    run_until_done(100, 100, "bcast");
    cmp_queue("bcast");
    for (int k = 0; k < NC && k < obs_q.size(); k++)
      check($sformatf("bcast core%0d", k), 64'(obs_q[k][PW-1 -: CW]), 64'(k));

    // Credit stall: six unicast entries, acks withheld
    do_reset();
    clear_rom();
    for (int i = 0; i < 6; i++) rom[i] = mk(i == 5, CW'(i % NC), AW'(16'h100 + i), DW'($urandom()));
    build_exp();
    pulse_start();
    repeat (30) tick(1'b1, 1'b0);
    check("stall count4", 64'(obs_q.size()), 64'd4);
    check("stall v low",  64'(cfg_v), 64'd0);
    check("stall busy",   64'(busy),  64'd1);
    tick(1'b1, 1'b1);
    repeat (8) tick(1'b1, 1'b0);
    check("stall count5", 64'(obs_q.size()), 64'd5);
    check("stall v low2", 64'(cfg_v), 64'd0);
    tick(1'b1, 1'b1);
    repeat (8) tick(1'b1, 1'b0);
    check("stall count6", 64'(obs_q.size()), 64'd6);
    check("stall no done", 64'(done), 64'd0);
    for (int j = 0; j < 3; j++) begin
      tick(1'b1, 1'b1);
      repeat (4) tick(1'b1, 1'b0);
    end
    check("drain wait", 64'(done), 64'd0);
    check("drain freeze", 64'(freeze), 64'hF);
    tick(1'b1, 1'b1);
    repeat (4) tick(1'b1, 1'b0);
    check("drain done", 64'(done), 64'd1);
    check("drain freeze0", 64'(freeze), 64'h0);
    check("stall err", 64'(err), 64'd0);
    cmp_queue("stall");

    // Backpressure mid-sequence
    do_reset();
    clear_rom();
    for (int i = 0; i < 5; i++)
      rom[i] = mk(i == 4, (i == 2) ? 8'hFF : CW'(i), AW'($urandom()), DW'($urandom()));
    build_exp();
    pulse_start();
    for (int n = 0; n < 50 && obs_q.size() < 2; n++) tick_auto(1'b1);
    repeat (5) tick_auto(1'b0);
    check("bp v held", 64'(cfg_v), 64'd1);
    check("bp pkt next", 64'(pkt), 64'((obs_q.size() < exp_q.size()) ? exp_q[obs_q.size()] : '0));
    run_until_done(100, 100, "bp");
    cmp_queue("bp");

    // No 'last' anywhere: stops after the final ROM entry
    do_reset();
    for (int i = 0; i < RE; i++) rom[i] = mk(1'b0, CW'($urandom_range(NC - 1, 0)), AW'(i), DW'($urandom()));
    build_exp();
    pulse_start();
    run_until_done(80, 60, "nolast");
    cmp_queue("nolast");
    check("nolast ptr", 64'(rom_addr), 64'd15);

    // Randomized ROM images with random ready and ack
    for (int it = 0; it < 6; it++) begin
      clear_rom();
      for (int i = 0; i < RE; i++) begin
        c = ($urandom_range(3, 0) == 0) ? 8'hFF : CW'($urandom_range(NC - 1, 0));
        rom[i] = mk($urandom_range(5, 0) == 0, c, AW'($urandom()), DW'($urandom()));
      end
      build_exp();
      do_reset();
      pulse_start();
      run_until_done(70, 50, $sformatf("rnd%0d", it));
      cmp_queue($sformatf("rnd%0d", it));
      check($sformatf("rnd%0d err", it), 64'(err), 64'd0);
      check($sformatf("rnd%0d freeze", it), 64'(freeze), 64'h0);
    end

    // Asynchronous reset while stalled in SEND on the second entry
    do_reset();
    clear_rom();
    for (int i = 0; i < 3; i++) rom[i] = mk(i == 2, CW'(i), AW'(16'h200 + i), DW'($urandom()));
    build_exp();
    pulse_start();
    repeat (3) tick(1'b1, 1'b0);
    repeat (5) tick(1'b0, 1'b0);
    check("mid count",  64'(obs_q.size()), 64'd1);
    check("mid addr",   64'(rom_addr), 64'd1);
    check("mid v",      64'(cfg_v), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async cfg_v",  64'(cfg_v),  64'd0);
    check("async busy",   64'(busy),   64'd0);
    check("async freeze", 64'(freeze), 64'hF);
    check("async addr",   64'(rom_addr), 64'd0);
    check("async pkt",    64'(pkt),    64'd0);
    check("async done",   64'(done),   64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    obs_q.delete();
    pulse_start();
    run_until_done(100, 100, "restart");
    cmp_queue("restart");

    check("stable under stall", 64'(stab_bad), 64'd0);
    check("credit limit", 64'(cred_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_cfg_boot_sequencer.md
# bp_cfg_boot_sequencer

Boot-time configuration sequencer for the processor's config network. After `start_i`, it walks a synchronous ROM of (core, addr, data) write entries and issues each one as a config packet, expanding broadcast entries to every core. Outstanding writes are limited by a credit counter. Once every write is acknowledged, it releases the per-core freeze. It sits between the off-chip boot source / loader ROM and the cfg links into each tile.

## Interface
Parameters:
- `num_core_p`, 1, number of cores receiving config; must be ≤ 2^`cfg_core_width_p`-1
- `cfg_core_width_p`, 8, core-id field width
- `cfg_addr_width_p`, 16, config address width
- `cfg_data_width_p`, 32, config data width
- `max_credits_p`, 4, maximum outstanding unacknowledged writes
- `rom_els_p`, 16, ROM depth
- `timeout_width_p`, 10, watchdog counter width (used only with the macro)

Ports:
- `clk_i`  in  1  clock
- `reset_n_i`  in  1  asynchronous, active-low reset
- `start_i`  in  1  one-cycle start pulse; honored only in IDLE
- `rom_v_o`  out  1  ROM read enable
- `rom_addr_o`  out  clog2(`rom_els_p`)  ROM read address
- `rom_data_i`  in  1+core+addr+data  entry as {last, core, addr, data}; valid the cycle after `rom_v_o`
- `cfg_pkt_o`  out  core+addr+data  {core, addr, data}
- `cfg_v_o`  out  1  packet valid
- `cfg_ready_i`  in  1  downstream accepts; a transfer occurs when `cfg_v_o & cfg_ready_i`
- `cfg_ack_v_i`  in  1  one write acknowledged; returns one credit
- `freeze_o`  out  `num_core_p`  per-core freeze
- `busy_o`  out  1  sequencing in progress
- `done_o`  out  1  all writes complete and acknowledged
- `err_o`  out  1  sticky error flag

## Operation
- **States:** IDLE, FETCH, LATCH, SEND, DRAIN, DONE.
- **Reset values:** state IDLE, `freeze_o` all ones, every other output 0, ROM pointer 0, credits = `max_credits_p`, core counter 0.
- **IDLE:** on `start_i`, go to FETCH.
- **FETCH:** drive `rom_v_o`=1 and `rom_addr_o`=ptr, then go to LATCH.
- **LATCH:** register `rom_data_i`, clear the core counter, then go to SEND.
- **SEND:**
  - `cfg_v_o` = (credits > 0).
  - Core field: the entry's core, or the core counter if the entry's core is all ones (broadcast).
  - On a transfer of a broadcast entry, the core counter increments. The entry is finished after core `num_core_p`-1. A unicast entry is finished after one transfer.
  - When an entry finishes: if `last` is set or ptr = `rom_els_p`-1, go to DRAIN. Otherwise increment ptr and go to FETCH.
- **Credits:**
  - A transfer subtracts 1; `cfg_ack_v_i` adds 1; both in the same cycle leave the count unchanged.
  - An ack while credits = `max_credits_p` (and no transfer that cycle) sets `err_o` and does not change the count.
- **DRAIN:** wait for credits = `max_credits_p`, then go to DONE.
- **DONE:** `freeze_o`=0 and `done_o`=1, held until reset. `start_i` is ignored.
- **`busy_o`:** 1 in FETCH, LATCH, SEND and DRAIN.
- **`start_i`:** ignored outside IDLE.
- **Reset mid-operation:** returns immediately to the reset values. A partially sent sequence is not resumed.

## Timing
- `rom_data_i` is sampled exactly one cycle after `rom_v_o`.
- Minimum per unicast entry: 3 cycles (FETCH, LATCH, SEND with ready and credit available).
- Broadcast entry: 2 + `num_core_p` cycles minimum.
- `cfg_pkt_o` is held stable while `cfg_v_o` is high and `cfg_ready_i` is low.
- `cfg_v_o` may drop with no transfer when credits reach 0. This is the only case where valid drops without a transfer.
- `done_o` and `freeze_o` change on the cycle after DRAIN observes full credits.

## Configuration
- **`BP_CFG_BOOT_WATCHDOG_EN` defined:**
  - A `timeout_width_p`-bit counter runs in SEND and DRAIN. It clears on any transfer or ack and saturates at all ones.
  - Reaching all ones sets `err_o` and moves the block to DONE with `freeze_o` still all ones and `done_o`=0.
- **Macro undefined:** no watchdog. `err_o` reflects credit overflow only, and the block may wait indefinitely.

## Test plan
- **Single unicast write:** ROM[0] = {1, 8'h00, 16'h0010, 32'hDEADBEEF}, ready and ack held high. Required: one packet {00, 0010, DEADBEEF}; `done_o`=1 with `freeze_o`=0.
- **Broadcast with `num_core_p`=4:** ROM[0] = {1, 8'hFF, 16'h0004, 32'h1}. Required: four packets with cores 0, 1, 2, 3 in order; then DONE.
- **Credit stall with `max_credits_p`=4:** 6 unicast entries, ack withheld. Required: exactly 4 transfers, then `cfg_v_o` low; each later ack allows one more transfer; DONE only after 6 acks.
- **Backpressure:** `cfg_ready_i` low for 5 cycles mid-sequence. Required: `cfg_pkt_o` stable, no duplicate or dropped packets.
- **Boundary and overflow:** ROM with no `last` bit set. Required: 16 entries are sent, then DRAIN. A spurious `cfg_ack_v_i` in IDLE sets `err_o`=1.
- **Reset and watchdog:** assert `reset_n_i` low during SEND. Required: outputs return to reset values asynchronously. With `BP_CFG_BOOT_WATCHDOG_EN`, no ack for 1023 cycles sets `err_o`=1, `done_o`=0, and `freeze_o` stays all ones.
